// File: rtl/cfg_stream_loader.sv
// Configuration stream loader: serialises a packed LSB-first word stream into
// NUM_CHAINS configuration chains, frame by frame, with a latch gap per frame.
module cfg_stream_loader #(
  parameter int NUM_CHAINS = 4,
  parameter int WORD_W     = 8,
  parameter int LEN_W      = 11,
  parameter int FRM_W      = 4,
  parameter int CH_W       = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
  input  logic [NUM_CHAINS*LEN_W-1:0] frame_len,
  input  logic [NUM_CHAINS*FRM_W-1:0] frame_num,
  input  logic                        s_valid,
  input  logic [WORD_W-1:0]           s_data,
  output logic                        s_ready,
  output logic [NUM_CHAINS-1:0]       bit_out,
  output logic [NUM_CHAINS-1:0]       chain_en,
  output logic [NUM_CHAINS-1:0]       frame_latch,
  output logic                        prgm_b,
  output logic [CH_W-1:0]             cur_chain,
  output logic                        done,
  output logic                        error
);

  localparam int BC_W = $clog2(WORD_W + 1);

  typedef enum logic [2:0] {IDLE, SEEK, SHIFT, GAP, FINISH} state_t;

  state_t                  state_r, state_n;
  logic [LEN_W-1:0]        len_r [NUM_CHAINS];
  logic [LEN_W-1:0]        len_n [NUM_CHAINS];
  logic [FRM_W-1:0]        num_r [NUM_CHAINS];
  logic [FRM_W-1:0]        num_n [NUM_CHAINS];
  logic [CH_W:0]           seek_from_r, seek_from_n;
  logic [CH_W-1:0]         cur_chain_r, cur_chain_n;
  logic [WORD_W-1:0]       buf_r, buf_n;
  logic [BC_W-1:0]         buf_cnt_r, buf_cnt_n;
  logic [LEN_W-1:0]        bit_cnt_r, bit_cnt_n, bit_cnt_inc_s;
  logic [FRM_W-1:0]        frm_cnt_r, frm_cnt_n, frm_cnt_inc_s;
  logic                    s_ready_r, s_ready_n;
  logic [NUM_CHAINS-1:0]   bit_out_r, bit_out_n;
  logic [NUM_CHAINS-1:0]   chain_en_r, chain_en_n;
  logic [NUM_CHAINS-1:0]   frame_latch_r, frame_latch_n;
  logic                    prgm_b_r, prgm_b_n;
  logic                    done_r, done_n;
  logic                    error_r, error_n;
  logic                    bad_cfg_s;
  logic                    found_s;
  logic [CH_W-1:0]         found_idx_s;
  logic [LEN_W-1:0]        cur_len_s;
  logic [FRM_W-1:0]        cur_num_s;

  assign cur_len_s     = len_r[cur_chain_r];
  assign cur_num_s     = num_r[cur_chain_r];
  assign bit_cnt_inc_s = (bit_cnt_r == {LEN_W{1'b1}}) ? bit_cnt_r : bit_cnt_r + 1'b1;
  assign frm_cnt_inc_s = (frm_cnt_r == {FRM_W{1'b1}}) ? frm_cnt_r : frm_cnt_r + 1'b1;

  // Flag a configuration that asks for frames of zero length on any chain
  always_comb begin
    bad_cfg_s = 1'b0;
    for (int i = 0; i < NUM_CHAINS; i++) begin
      if ((frame_num[i*FRM_W +: FRM_W] != {FRM_W{1'b0}}) &&
          (frame_len[i*LEN_W +: LEN_W] == {LEN_W{1'b0}})) begin
        bad_cfg_s = 1'b1;
      end else begin
        bad_cfg_s = bad_cfg_s;
      end
    end
  end

  // Lowest chain at or above seek_from_r that has frames to load
  always_comb begin
    found_s     = 1'b0;
    found_idx_s = {CH_W{1'b0}};
    for (int i = NUM_CHAINS - 1; i >= 0; i--) begin
      if (((CH_W + 1)'(i) >= seek_from_r) && (num_r[i] != {FRM_W{1'b0}})) begin
        found_s     = 1'b1;
        found_idx_s = CH_W'(i);
      end else begin
        found_s     = found_s;
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n       = state_r;
    seek_from_n   = seek_from_r;
    cur_chain_n   = cur_chain_r;
    buf_n         = buf_r;
    buf_cnt_n     = buf_cnt_r;
    bit_cnt_n     = bit_cnt_r;
    frm_cnt_n     = frm_cnt_r;
    bit_out_n     = {NUM_CHAINS{1'b0}};
    chain_en_n    = {NUM_CHAINS{1'b0}};
    frame_latch_n = {NUM_CHAINS{1'b0}};
    prgm_b_n      = prgm_b_r;
    done_n        = done_r;
    error_n       = error_r;
    for (int i = 0; i < NUM_CHAINS; i++) begin
      len_n[i] = len_r[i];
      num_n[i] = num_r[i];
    end

    case (state_r)
      IDLE: begin
        if (start && !abort) begin
          for (int i = 0; i < NUM_CHAINS; i++) begin
            len_n[i] = frame_len[i*LEN_W +: LEN_W];
            num_n[i] = frame_num[i*FRM_W +: FRM_W];
          end
          done_n    = 1'b0;
          buf_cnt_n = {BC_W{1'b0}};
          if (bad_cfg_s) begin
            error_n  = 1'b1;
            prgm_b_n = 1'b1;
          end else begin
            error_n     = 1'b0;
            prgm_b_n    = 1'b0;
            seek_from_n = {(CH_W + 1){1'b0}};
            state_n     = SEEK;
          end
        end else begin
          state_n = IDLE;
        end
      end
      SEEK: begin
        if (found_s) begin
          cur_chain_n = found_idx_s;
          bit_cnt_n   = {LEN_W{1'b0}};
          frm_cnt_n   = {FRM_W{1'b0}};
          state_n     = SHIFT;
        end else begin
          done_n   = 1'b1;
          prgm_b_n = 1'b1;
          state_n  = FINISH;
        end
      end
      SHIFT: begin
        if (buf_cnt_r != {BC_W{1'b0}}) begin
          bit_out_n[cur_chain_r]  = buf_r[0];
          chain_en_n[cur_chain_r] = 1'b1;
          buf_n     = buf_r >> 1;
          buf_cnt_n = buf_cnt_r - 1'b1;
          bit_cnt_n = bit_cnt_inc_s;
          if (bit_cnt_inc_s == cur_len_s) begin
            state_n = GAP;
          end else begin
            state_n = SHIFT;
          end
        end else if (s_valid && s_ready_r) begin
          buf_n     = s_data;
          buf_cnt_n = BC_W'(WORD_W);
          bit_out_n = bit_out_r;
        end else begin
          bit_out_n = bit_out_r;
        end
      end
      GAP: begin
        frame_latch_n[cur_chain_r] = 1'b1;
        frm_cnt_n = frm_cnt_inc_s;
        bit_cnt_n = {LEN_W{1'b0}};
        if (frm_cnt_inc_s < cur_num_s) begin
          state_n = SHIFT;
        end else begin
          seek_from_n = {1'b0, cur_chain_r} + 1'b1;
          state_n     = SEEK;
        end
      end
      FINISH: begin
        buf_n     = {WORD_W{1'b0}};
        buf_cnt_n = {BC_W{1'b0}};
        state_n   = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Abort overrides everything, including a simultaneous start
    if (abort && (state_r != IDLE)) begin
      state_n       = IDLE;
      prgm_b_n      = 1'b1;
      chain_en_n    = {NUM_CHAINS{1'b0}};
      frame_latch_n = {NUM_CHAINS{1'b0}};
      bit_out_n     = {NUM_CHAINS{1'b0}};
      buf_n         = {WORD_W{1'b0}};
      buf_cnt_n     = {BC_W{1'b0}};
      done_n        = 1'b0;
      error_n       = 1'b0;
    end else begin
      state_n = state_n;
    end

    s_ready_n = (state_n == SHIFT) && (buf_cnt_n == {BC_W{1'b0}});
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      seek_from_r   <= {(CH_W + 1){1'b0}};
      cur_chain_r   <= {CH_W{1'b0}};
      buf_r         <= {WORD_W{1'b0}};
      buf_cnt_r     <= {BC_W{1'b0}};
      bit_cnt_r     <= {LEN_W{1'b0}};
      frm_cnt_r     <= {FRM_W{1'b0}};
      s_ready_r     <= 1'b0;
      bit_out_r     <= {NUM_CHAINS{1'b0}};
      chain_en_r    <= {NUM_CHAINS{1'b0}};
      frame_latch_r <= {NUM_CHAINS{1'b0}};
      prgm_b_r      <= 1'b1;
      done_r        <= 1'b0;
      error_r       <= 1'b0;
      for (int i = 0; i < NUM_CHAINS; i++) begin
        len_r[i] <= {LEN_W{1'b0}};
        num_r[i] <= {FRM_W{1'b0}};
      end
    end else begin
      state_r       <= state_n;
      seek_from_r   <= seek_from_n;
      cur_chain_r   <= cur_chain_n;
      buf_r         <= buf_n;
      buf_cnt_r     <= buf_cnt_n;
      bit_cnt_r     <= bit_cnt_n;
      frm_cnt_r     <= frm_cnt_n;
      s_ready_r     <= s_ready_n;
      bit_out_r     <= bit_out_n;
      chain_en_r    <= chain_en_n;
      frame_latch_r <= frame_latch_n;
      prgm_b_r      <= prgm_b_n;
      done_r        <= done_n;
      error_r       <= error_n;
      for (int i = 0; i < NUM_CHAINS; i++) begin
        len_r[i] <= len_n[i];
        num_r[i] <= num_n[i];
      end
    end
  end

  assign s_ready     = s_ready_r;
  assign bit_out     = bit_out_r;
  assign chain_en    = chain_en_r;
  assign frame_latch = frame_latch_r;
  assign prgm_b      = prgm_b_r;
  assign cur_chain   = cur_chain_r;
  assign done        = done_r;
  assign error       = error_r;

endmodule

// File: tb/tb_cfg_stream_loader.sv
// Scoreboard bench for cfg_stream_loader: a frame-level model queues the expected
// shift/latch events, a negedge monitor pops and compares them.
module tb_cfg_stream_loader;
  localparam int NC = 4;
  localparam int W  = 8;
  localparam int LW = 11;
  localparam int FW = 4;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [NC*LW-1:0] frame_len = '0;
  logic [NC*FW-1:0] frame_num = '0;
  logic s_valid = 1'b0;
  logic [W-1:0] s_data = '0;
  logic s_ready;
  logic [NC-1:0] bit_out, chain_en, frame_latch;
  logic prgm_b, done, error;
  logic [CW-1:0] cur_chain;

  cfg_stream_loader #(.NUM_CHAINS(NC), .WORD_W(W), .LEN_W(LW), .FRM_W(FW), .CH_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .frame_len(frame_len), .frame_num(frame_num),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .bit_out(bit_out), .chain_en(chain_en), .frame_latch(frame_latch),
    .prgm_b(prgm_b), .cur_chain(cur_chain), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {bit is_latch; int ch; bit b;} ev_t;
  ev_t          exp_q[$];
  logic [W-1:0] word_q[$];
  int vec_cnt = 0, err_cnt = 0;
  int tick = 0, last_latch_tick = -100;
  int bits_seen = 0, pulses = 0, fires = 0;
  int exp_words = 0, exp_bits = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    vec_cnt++;
    if (act !== expv) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  initial forever begin
    @(posedge clk);
    tick++;
  end

  // Monitor: every shift or latch cycle must match the next queued event
  initial forever begin
    ev_t e;
    logic [NC-1:0] oh;
    @(negedge clk);
    if (reset && ((chain_en != '0) || (frame_latch != '0))) begin
      if (chain_en != '0) begin
        pulses++;
        bits_seen++;
      end
      if (frame_latch != '0) last_latch_tick = tick;
      if (exp_q.size() == 0) begin
        check("unexpected_event", {chain_en, frame_latch}, '0);
      end else begin
        e  = exp_q.pop_front();
        oh = NC'(1) << e.ch;
        if (e.is_latch)
          check("latch_evt", {chain_en, bit_out, frame_latch, prgm_b}, {4'b0, 4'b0, oh, 1'b0});
        else
          check("shift_evt", {chain_en, bit_out, frame_latch, prgm_b},
                {oh, (e.b ? oh : 4'b0), 4'b0, 1'b0});
      end
    end
  end

  // Reference model: chains in order, frames in order, bits consumed LSB-first from a dense stream
  task automatic build_model(input int len[NC], input int num[NC], input bit fixed, input logic [W-1:0] fword);
    bit bits_q[$];
    logic [W-1:0] w;
    ev_t e;
    exp_bits = 0;
    for (int c = 0; c < NC; c++) exp_bits += len[c] * num[c];
    exp_words = (exp_bits + W - 1) / W;
    for (int k = 0; k < exp_words; k++) begin
      w = fixed ? fword : W'($urandom);
      word_q.push_back(w);
      for (int j = 0; j < W; j++) bits_q.push_back(w[j]);
    end
    for (int c = 0; c < NC; c++)
      for (int f = 0; f < num[c]; f++) begin
        for (int b = 0; b < len[c]; b++) begin
          e.is_latch = 1'b0; e.ch = c; e.b = bits_q.pop_front();
          exp_q.push_back(e);
        end
        e.is_latch = 1'b1; e.ch = c; e.b = 1'b0;
        exp_q.push_back(e);
      end
  endtask

  // stall: 0 always valid, 1 random gaps, 2 ten-cycle drop mid-frame
  task automatic run(input int len[NC], input int num[NC], input bit fixed, input logic [W-1:0] fword,
                     input int stall, input int abort_at, input int reset_at);
    int cyc, done_tick;
    for (int i = 0; i < NC; i++) begin
      frame_len[i*LW +: LW] = LW'(len[i]);
      frame_num[i*FW +: FW] = FW'(num[i]);
    end
    exp_q.delete(); word_q.delete();
    build_model(len, num, fixed, fword);
    fires = 0; pulses = 0; bits_seen = 0; last_latch_tick = -100;
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    cyc = 0; done_tick = -1;
    while (cyc < 4000) begin
      if (done) begin done_tick = tick; break; end
      if (abort_at >= 0 && bits_seen >= abort_at) begin
        abort = 1'b1; s_valid = 1'b0; exp_q.delete();
        @(negedge clk); #1 abort = 1'b0;
        check("abort_state", {prgm_b, chain_en, s_ready, done, error}, {1'b1, 4'b0, 1'b0, 1'b0, 1'b0});
        word_q.delete();
        return;
      end
      if (reset_at >= 0 && bits_seen >= reset_at) begin
        check("pre_reset_chain", cur_chain, 2'd1);
        #2 reset = 1'b0;
        #1 check("async_reset", {s_ready, bit_out, chain_en, frame_latch, prgm_b, cur_chain, done, error},
                 {1'b0, 4'b0, 4'b0, 4'b0, 1'b1, 2'b0, 1'b0, 1'b0});
        exp_q.delete(); word_q.delete(); s_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1 reset = 1'b1; s_valid = 1'b1;
        repeat (5) @(negedge clk);
        #1 check("idle_after_reset", {prgm_b, s_ready, chain_en, done}, {1'b1, 1'b0, 4'b0, 1'b0});
        s_valid = 1'b0;
        return;
      end
      case (stall)
        1:       s_valid = ($urandom_range(0, 3) != 0);
        2:       s_valid = !(cyc >= 30 && cyc < 40);
        default: s_valid = 1'b1;
      endcase
      s_data = (word_q.size() != 0) ? word_q[0] : W'($urandom);
      if (s_valid && s_ready) begin
        fires++;
        if (word_q.size() != 0) void'(word_q.pop_front());
      end
      @(negedge clk); #1 cyc++;
    end
    s_valid = 1'b0;
    check("done_seen", (done_tick >= 0), 1'b1);
    if (exp_bits > 0) check("done_timing", done_tick, last_latch_tick + 1);
    check("events_left", exp_q.size(), 0);
    check("chain_en_pulses", pulses, exp_bits);
    check("handshakes", fires, exp_words);
    check("end_status", {prgm_b, s_ready, error}, {1'b1, 1'b0, 1'b0});
  endtask

  initial begin
    int len[NC], num[NC];
    repeat (3) @(negedge clk);
    check("reset_values", {s_ready, bit_out, chain_en, frame_latch, prgm_b, cur_chain, done, error},
          {1'b0, 4'b0, 4'b0, 4'b0, 1'b1, 2'b0, 1'b0, 1'b0});
    #1 reset = 1'b1;
    @(negedge clk);

    run('{48, 48, 48, 48}, '{4, 0, 0, 0}, 1'b1, 8'hA5, 1, -1, -1);
    run('{5, 3, 0, 0}, '{1, 1, 0, 0}, 1'b1, 8'b10110011, 0, -1, -1);
    run('{48, 48, 48, 48}, '{4, 0, 0, 0}, 1'b1, 8'hA5, 2, -1, -1);

    // Bad configuration: error next cycle, nothing shifted, no handshake
    frame_len = '0; frame_len[0 +: LW] = 11'd4;
    frame_num = '0; frame_num[0 +: FW] = 4'd1; frame_num[FW +: FW] = 4'd2;
    exp_q.delete();
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    check("bad_cfg", {error, prgm_b, s_ready, done}, {1'b1, 1'b1, 1'b0, 1'b0});
    s_valid = 1'b1;
    repeat (5) @(negedge clk);
    #1 check("bad_cfg_idle", {error, prgm_b, s_ready, chain_en}, {1'b1, 1'b1, 1'b0, 4'b0});
    s_valid = 1'b0;

    run('{48, 48, 48, 48}, '{4, 0, 0, 0}, 1'b0, 8'h00, 1, 20, -1);
    run('{48, 48, 48, 48}, '{4, 0, 0, 0}, 1'b0, 8'h00, 1, -1, -1);

    // start together with abort while idle: abort wins, done stays set
    @(negedge clk); #1 start = 1'b1; abort = 1'b1;
    @(negedge clk); #1 start = 1'b0; abort = 1'b0;
    @(negedge clk); #1 check("start_abort_idle", {prgm_b, done}, {1'b1, 1'b1});

    run('{16, 24, 0, 0}, '{1, 2, 0, 0}, 1'b0, 8'h00, 1, -1, 30);

    for (int t = 0; t < 6; t++) begin
      for (int c = 0; c < NC; c++) begin
        len[c] = $urandom_range(1, 40);
        num[c] = $urandom_range(0, 3);
      end
      run(len, num, 1'b0, 8'h00, 1, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/cfg_stream_loader.md
Name: cfg_stream_loader

Overview:
- Parametrised configuration loader that replaces per-chain ad-hoc bitstream shifting with a single controller.
- Accepts a dense, LSB-first packed bitstream as WORD_W-bit words over a valid/ready handshake.
- Serialises the stream into NUM_CHAINS configuration chains (CB, SB, CLB, ...), one chain at a time.
- Per chain: loads a programmable number of frames of programmable length, with a one-cycle latch gap after each frame. Drives the global active-low program flag and done/error status.

Parameters:
- NUM_CHAINS, 4, number of serial configuration chains.
- WORD_W, 8, input word width in bits.
- LEN_W, 11, width of per-chain frame-length field (max frame 2^LEN_W-1 bits).
- FRM_W, 4, width of per-chain frame-count field.
- CH_W, 2, width of chain index (>= clog2(NUM_CHAINS)).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load when idle, ignored otherwise.
- abort  in  1  synchronous abort; returns the block to IDLE next cycle.
- frame_len  in  NUM_CHAINS*LEN_W  bits per frame; chain i at [i*LEN_W +: LEN_W]; sampled at start.
- frame_num  in  NUM_CHAINS*FRM_W  frames per chain; 0 means skip the chain; sampled at start.
- s_valid  in  1  input word valid.
- s_data  in  WORD_W  input word; bit 0 is shifted out first.
- s_ready  out  1  word accepted when s_valid && s_ready.
- bit_out  out  NUM_CHAINS  serial data, one bit per chain.
- chain_en  out  NUM_CHAINS  shift enable; chain i captures bit_out[i] on the cycle chain_en[i]=1.
- frame_latch  out  NUM_CHAINS  one-cycle pulse on the gap cycle after each frame.
- prgm_b  out  1  active low; 0 while a load is in progress.
- cur_chain  out  CH_W  index of the chain being loaded.
- done  out  1  sticky; set when all chains have loaded, cleared by start.
- error  out  1  sticky; set on a bad configuration, cleared by start.

Behaviour:
- Reset values: s_ready=0, bit_out=0, chain_en=0, frame_latch=0, prgm_b=1, cur_chain=0, done=0, error=0, state=IDLE.
- FSM states: IDLE, SEEK, SHIFT, GAP, FINISH.
- IDLE + start:
  - Latch frame_len and frame_num; clear done and error; prgm_b<=0; go to SEEK.
  - Any chain with frame_num!=0 and frame_len==0 → error<=1, prgm_b<=1, go to IDLE. Nothing is shifted.
- SEEK:
  - Advance cur_chain to the next chain, starting at 0, with frame_num!=0. This takes 1 cycle.
  - If none remain → FINISH.
- SHIFT, input buffer:
  - Internal WORD_W shift buffer plus a bit count.
  - s_ready=1 only in SHIFT while the buffer is empty.
  - An accepted word is usable the next cycle.
- SHIFT, output:
  - Each cycle the buffer is non-empty: bit_out[cur_chain]<=buffer[0], chain_en[cur_chain]<=1, buffer shifts right, bit counter increments.
  - Outputs are registered. The first bit appears 2 cycles after the first handshake.
- Underflow (buffer empty, s_valid=0): stall. chain_en=0, bit_out holds, counter holds. No error is raised.
- Inactive chains: bit_out and chain_en stay 0.
- Frame end: after frame_len bits → GAP. frame_latch[cur_chain]=1 for exactly 1 cycle; no shift occurs.
- After GAP:
  - Frame counter increments.
  - If frame counter < frame_num → SHIFT.
  - Else → SEEK for the next chain.
- Packing: the stream is dense across frame and chain boundaries. Leftover buffer bits carry into the next frame or chain. Unused bits of the final word are discarded at FINISH.
- FINISH: buffer flushed, prgm_b<=1, done<=1, go to IDLE.
- abort in any non-IDLE state: next cycle IDLE, prgm_b=1, chain_en=0, buffer cleared, done=0, error=0.
- start while busy: ignored.
- start and abort in the same cycle: abort wins.
- Reset mid-load: all outputs return to reset values immediately (asynchronous).
- All counters saturate; no wrap-around.

Test Plan:
- NUM_CHAINS=4, lengths {48,48,48,48}, frames {4,0,0,0}; stream 0xA5 repeated → 192 chain_en[0] pulses in 4 bursts of 48, each followed by a frame_latch[0] pulse. bit_out[0] pattern is 1,0,1,0,0,1,0,1,... prgm_b low throughout. done=1 one cycle after the last latch.
- Lengths {5,3,0,0}, frames {1,1,0,0}; single word 0b10110011 → chain 0 gets bits 1,1,0,0,1 then a latch. SEEK cycle. Chain 1 gets 1,0,1 then a latch. done=1, no extra handshake.
- Same as the first case, but s_valid dropped for 10 cycles mid-frame → chain_en low for those cycles, counter holds, output bit order unchanged, total pulses still 192.
- Frames {1,2,0,0}, len[1]=0 → error=1 the cycle after start, prgm_b stays 1, no chain_en pulses, s_ready=0.
- abort asserted at bit 20 of chain 0 → next cycle IDLE, prgm_b=1, chain_en=0. A new start reloads from chain 0 bit 0 with correct data.
- reset pulled low mid-SHIFT → all outputs at reset values asynchronously. After release the block stays in IDLE until start.
